// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side handshake bundle for the UART transmitter.
//   tx_start_i      host -> tx   request to send din_i (honoured only while idle)
//   din_i[7:0]      host -> tx   word to send, LSB first
//   tx_busy_o       tx -> host   frame in progress
//   tx_done_tick_o  tx -> host   one-cycle pulse on the last tick of the stop bit
interface uart_tx_if;
    logic       tx_start_i;
    logic [7:0] din_i;
    logic       tx_busy_o;
    logic       tx_done_tick_o;

    modport master (
        output tx_start_i,
        output din_i,
        input  tx_busy_o,
        input  tx_done_tick_o
    );

    modport slave (
        input  tx_start_i,
        input  din_i,
        output tx_busy_o,
        output tx_done_tick_o
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serializes a word into start, data (LSB first), optional parity and
// stop bits. Bit timing is counted in 16x oversampling ticks.
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   sample_tick_i  16x oversampling strobe, one clk_i cycle wide
//   host           uart_tx_if.slave: tx_start_i, din_i, tx_busy_o, tx_done_tick_o
//   tx_o           registered serial line, idles high
module uart_tx #(
    parameter int WordLength   = 8,
    parameter int StopBitTicks = 16,
    parameter bit ParityEn     = 1'b0,
    parameter bit ParityOdd    = 1'b0
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     sample_tick_i,
    uart_tx_if.slave host,
    output logic     tx_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [4:0] BitLast  = 5'd15;
    localparam logic [4:0] StopLast = 5'(StopBitTicks - 1);
    localparam logic [2:0] WordLast = 3'(WordLength - 1);
    // Bits of din_i that belong to the frame; the rest never reach data or parity.
    localparam logic [7:0] WordMask = 8'((1 << WordLength) - 1);

    state_e     state_q, state_d;
    logic [4:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       tx_done_tick;

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tx_d         = tx_q;
        tx_done_tick = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (host.tx_start_i) begin
                    shift_d  = host.din_i;
                    parity_d = (^(host.din_i & WordMask)) ^ ParityOdd;
                    tick_d   = 5'd0;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end

            START: begin
                if (sample_tick_i) begin
                    if (tick_q == BitLast) begin
                        tick_d  = 5'd0;
                        bit_d   = 3'd0;
                        tx_d    = shift_q[0];
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end

            DATA: begin
                if (sample_tick_i) begin
                    if (tick_q == BitLast) begin
                        tick_d  = 5'd0;
                        shift_d = shift_q >> 1;
                        if (bit_q == WordLast) begin
                            if (ParityEn) begin
                                tx_d    = parity_q;
                                state_d = PARITY;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = STOP;
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                            // Next bit is the one about to move into position 0.
                            tx_d  = shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end

            PARITY: begin
                if (sample_tick_i) begin
                    if (tick_q == BitLast) begin
                        tick_d  = 5'd0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end

            STOP: begin
                if (sample_tick_i) begin
                    if (tick_q == StopLast) begin
                        // Done is combinational so it lines up with the final stop tick.
                        tx_done_tick = 1'b1;
                        tick_d       = 5'd0;
                        state_d      = IDLE;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            tick_q   <= 5'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign tx_o                = tx_q;
    assign host.tx_busy_o      = (state_q != IDLE);
    assign host.tx_done_tick_o = tx_done_tick;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx in five parameter
// configurations against a tick-indexed frame model.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tick;
    logic [7:0] din;
    logic [4:0] start_v;

    logic tx0, tx1, tx2, tx3, tx4;
    logic [4:0] tx_w, busy_w, done_w;

    uart_tx_if if0();
    uart_tx_if if1();
    uart_tx_if if2();
    uart_tx_if if3();
    uart_tx_if if4();

    assign if0.tx_start_i = start_v[0];
    assign if1.tx_start_i = start_v[1];
    assign if2.tx_start_i = start_v[2];
    assign if3.tx_start_i = start_v[3];
    assign if4.tx_start_i = start_v[4];
    assign if0.din_i = din;
    assign if1.din_i = din;
    assign if2.din_i = din;
    assign if3.din_i = din;
    assign if4.din_i = din;

    assign tx_w   = {tx4, tx3, tx2, tx1, tx0};
    assign busy_w = {if4.tx_busy_o, if3.tx_busy_o, if2.tx_busy_o, if1.tx_busy_o, if0.tx_busy_o};
    assign done_w = {if4.tx_done_tick_o, if3.tx_done_tick_o, if2.tx_done_tick_o,
                     if1.tx_done_tick_o, if0.tx_done_tick_o};

    // 8N1
    uart_tx #(.WordLength(8), .StopBitTicks(16), .ParityEn(1'b0), .ParityOdd(1'b0)) u0 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .host(if0), .tx_o(tx0));
    // 8E1
    uart_tx #(.WordLength(8), .StopBitTicks(16), .ParityEn(1'b1), .ParityOdd(1'b0)) u1 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .host(if1), .tx_o(tx1));
    // 8O1
    uart_tx #(.WordLength(8), .StopBitTicks(16), .ParityEn(1'b1), .ParityOdd(1'b1)) u2 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .host(if2), .tx_o(tx2));
    // 8N1.5
    uart_tx #(.WordLength(8), .StopBitTicks(24), .ParityEn(1'b0), .ParityOdd(1'b0)) u3 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .host(if3), .tx_o(tx3));
    // 7N1
    uart_tx #(.WordLength(7), .StopBitTicks(16), .ParityEn(1'b0), .ParityOdd(1'b0)) u4 (
        .clk_i(clk), .rst_i(rst), .sample_tick_i(tick), .host(if4), .tx_o(tx4));

    // Configuration of each instance, as seen by the model.
    int cw  [5] = '{8, 8, 8, 8, 7};
    int cpe [5] = '{0, 1, 1, 0, 0};
    int cpo [5] = '{0, 0, 1, 0, 0};
    int cst [5] = '{16, 16, 16, 24, 16};

    int checks = 0;
    int errors = 0;

    // Model state: expected line level for every tick of the frame in flight.
    bit m_lv[$];
    bit m_act = 1'b0;
    int m_n = 0;
    int m_acc_cyc = 0;

    int cyc = 0;
    int tick_per = 1;   // 0 = random ticks
    int done_cnt = 0;
    int last_done_rel = -1;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame = start(16 ticks 0), data LSB first (16 ticks each),
    // optional parity (16 ticks), stop (cst ticks of 1).
    task automatic build_frame(input int d, input logic [7:0] data);
        int ones;
        bit p;
        m_lv.delete();
        ones = 0;
        repeat (16) m_lv.push_back(1'b0);
        for (int i = 0; i < cw[d]; i++) begin
            repeat (16) m_lv.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (cpe[d] != 0) begin
            p = ((ones % 2) != 0) ^ (cpo[d] != 0);
            repeat (16) m_lv.push_back(p);
        end
        repeat (cst[d]) m_lv.push_back(1'b1);
    endtask

    // One clock cycle on DUT d: drive inputs, compare outputs against the
    // model, then advance the model and the clock.
    task automatic step(input int d, input bit st, input logic [7:0] dv, input bit r);
        bit tk;
        logic e_tx, e_busy, e_done;
        if (tick_per == 0) tk = 1'($urandom_range(0, 1));
        else               tk = ((cyc % tick_per) == 0);
        tick     = tk;
        din      = dv;
        start_v  = '0;
        start_v[d] = st;
        rst      = r;
        #1;
        if (m_act) begin
            e_tx   = m_lv[m_n];
            e_busy = 1'b1;
            e_done = tk && (m_n == m_lv.size() - 1);
        end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
            e_done = 1'b0;
        end
        chk("tx", tx_w[d], e_tx);
        chk("busy", busy_w[d], e_busy);
        chk("done", done_w[d], e_done);
        if (done_w[d] === 1'b1) begin
            done_cnt++;
            last_done_rel = cyc - m_acc_cyc;
        end
        if (r) begin
            m_act = 1'b0;
        end else if (m_act) begin
            if (tk) begin
                m_n++;
                if (m_n == m_lv.size()) m_act = 1'b0;
            end
        end else if (st) begin
            build_frame(d, dv);
            m_n       = 0;
            m_act     = 1'b1;
            m_acc_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Send one frame; din is scrambled after acceptance to prove it is not resampled.
    task automatic run_frame(input int d, input logic [7:0] data, input int exp_done_rel);
        int dc0;
        int guard;
        dc0   = done_cnt;
        guard = 0;
        step(d, 1'b1, data, 1'b0);
        while (m_act && guard < 3000) begin
            step(d, 1'b0, 8'($urandom), 1'b0);
            guard++;
        end
        chk_int("done_count", done_cnt - dc0, 1);
        if (exp_done_rel >= 0) chk_int("done_cycle", last_done_rel, exp_done_rel);
        step(d, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int dc0;
        int guard;

        rst     = 1'b1;
        tick    = 1'b0;
        din     = 8'h00;
        start_v = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("reset_tx", tx_w[k], 1'b1);
            chk("reset_busy", busy_w[k], 1'b0);
            chk("reset_done", done_w[k], 1'b0);
        end
        rst = 1'b0;

        // 8N1 framing, tick every cycle
        tick_per = 1;
        step(0, 1'b0, 8'h00, 1'b0);
        run_frame(0, 8'hA5, 160);

        // Even and odd parity
        run_frame(1, 8'hA5, 176);
        run_frame(2, 8'hA5, 176);

        // 1.5 stop bits with a tick every 4th cycle
        tick_per = 4;
        run_frame(3, 8'h00, -1);
        run_frame(3, 8'h5A, -1);
        tick_per = 1;

        // 7-bit word: bit 7 must never appear
        run_frame(4, 8'hFF, 144);
        run_frame(4, 8'h80, 144);

        // Start held high: 0x3C then 0xC3 back to back
        dc0   = done_cnt;
        guard = 0;
        step(0, 1'b1, 8'h3C, 1'b0);
        while (m_act && guard < 400) begin
            step(0, 1'b1, 8'hC3, 1'b0);
            guard++;
        end
        step(0, 1'b1, 8'hC3, 1'b0);
        chk_int("b2b_second_accept", last_done_rel, 160);
        guard = 0;
        while (m_act && guard < 400) begin
            step(0, 1'b0, 8'h3C, 1'b0);
            guard++;
        end
        step(0, 1'b0, 8'h00, 1'b0);
        chk_int("b2b_done_count", done_cnt - dc0, 2);

        // Reset in the middle of the data bits
        dc0 = done_cnt;
        step(0, 1'b1, 8'h96, 1'b0);
        repeat (60) step(0, 1'b0, 8'h00, 1'b0);
        step(0, 1'b0, 8'h00, 1'b1);
        chk("midrst_tx", tx_w[0], 1'b1);
        chk("midrst_busy", busy_w[0], 1'b0);
        repeat (200) step(0, 1'b0, 8'h00, 1'b0);
        chk_int("midrst_no_done", done_cnt - dc0, 0);
        run_frame(0, 8'h69, 160);

        // Random data on every configuration with irregular ticks
        tick_per = 0;
        for (int f = 0; f < 10; f++) begin
            run_frame(f % 5, 8'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
